fb_page_reader: RTL and testbench
=================================

# fb_page_reader

Reads the CHIP-8 framebuffer (64×32 pixels, 256 bytes) out of shared memory, which the CPU writes. Streams it as 256 column-major page bytes, the SSD1306-style vertical 8-pixel format, to the display driver. The block sits between the memory arbiter's read port and the display stream input. One `start` pulse produces one full frame.

## Interface

Parameters:
- `FB_BASE`, default `12'hF00`: base address of the framebuffer in the 4 KiB memory.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `start`  in  1: one-cycle request to transfer a frame; ignored unless idle.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `mem_req`  out  1: read request; held until `mem_ack`.
- `mem_addr`  out  12: read address; stable while `mem_req` is high.
- `mem_ack`  in  1: read completes this cycle.
- `mem_data`  in  8: read data, valid in the `mem_ack` cycle.
- `out_data`  out  8: page byte; bit k is pixel row `8·page+k`.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: the sink accepts the byte when `out_valid & out_ready`.
- `out_last`  out  1: marks the final byte of the frame (page 3, column 63).
- `done`  out  1: one-cycle pulse after the final byte is accepted.

## Operation

- Framebuffer layout:
  - Row-major, 8 bytes per row.
  - Byte MSB is the leftmost pixel.
  - Pixel (x,y) is bit `7-(x%8)` of `FB_BASE + 8y + x/8`.
- Output order: page p = 0..3 (outer loop), then column x = 0..63.
  - Bit k of the byte for (p,x) is pixel (x, 8p+k).
- Work proceeds in 32 groups, indexed by p (2 bits) and g = x/8 (3 bits).
  - Per group: READ 8 bytes for k = 0..7, then EMIT 8 bytes for x = 8g..8g+7.
- Read address: `FB_BASE + {p, k, g}`, an 8-bit offset. The addition wraps modulo 4096.
- State machine:
  - IDLE → READ on `start`. Clear p, g and k.
  - READ: `mem_req=1`. On `mem_ack`, store `mem_data` in `buf[k]` and increment k. On the 8th ack, go to EMIT with column index c=0.
  - EMIT: `out_valid=1` and `out_data[k] = buf[k][7-c]`.
    - On handshake, increment c.
    - On the 8th handshake, advance g (carry into p) and go to READ.
    - After group (3,7), go to DONE instead.
  - DONE: `done=1` for one cycle, then IDLE.
- `start` outside IDLE has no effect. A `start` coincident with `reset` is dropped.
- `reset` in any state, including mid-frame:
  - Next state is IDLE and all counters clear.
  - The partial frame is abandoned; no `out_last` or `done` is issued.
- `out_ready` may be high at any time. The block never drops or repeats a byte.

## Timing

- Reset values: `busy`, `mem_req`, `out_valid`, `out_last` and `done` are 0. `mem_addr` and `out_data` are 0.
- `start` at cycle 0 → `mem_req=1` with `mem_addr=FB_BASE` at cycle 1.
- Read issue: each ack moves to the next address in the following cycle.
  - With zero-wait acks, 8 reads take 8 cycles.
  - `mem_req` never drops between the reads of a group.
- First `out_valid` appears the cycle after the 8th ack.
- With the sink always ready, one byte per cycle for 8 cycles, then the next READ.
- Minimum frame: 32×(8+8) = 512 cycles from the first request to the last byte, plus 1 cycle for `done`.
- `out_last` is asserted only together with `out_valid` on byte 255.
- `done` is high the cycle after the byte-255 handshake. `busy` falls in the same cycle `done` rises.
- All outputs are registered or decoded from state registers only. There is no combinational path from `out_ready` or `mem_ack` to any output.

## Structure

- Shared package holds:
  - Framebuffer geometry: `FB_W=64`, `FB_H=32`, `FB_PAGES=4`, `FB_BYTES=256`.
  - The default `FB_BASE` value.
  - The state enum: IDLE, READ, EMIT, DONE.
- Sub-module `fb_transpose8`: an 8×8-bit buffer with a write port (row k, byte) and a column read (c → byte). Counters and the FSM stay in the top level.

## Test plan

- Memory all zero, sink always ready, zero-wait ack:
  - First 9 read addresses are F00, F08, …, F38, then F01.
  - Output is 256 bytes of 0x00 with `out_last` on byte 255.
  - `done` comes 1 cycle later.
- Pixel (0,0) set via `mem[F00]=80`: output byte 0 = 0x01; all others 0x00.
- Pixel (63,31) set via `mem[FFF]=01`: byte 255 = 0x80 with `out_last=1`; all others 0x00.
- Checkerboard `mem[F00..FFF] = AA/55` alternating by row, with `out_ready` toggling every cycle and `mem_ack` delayed 3 cycles:
  - Outputs alternate 0x55/0xAA.
  - Exactly 256 handshakes.
  - `mem_addr` is stable while `mem_req` is high.
- `start` pulsed while busy: no restart; exactly one `done`.
- `reset` asserted at byte 100:
  - Next cycle all outputs are 0 and there is no `done`.
  - A fresh `start` yields a full, correct frame from address F00.

Source files
------------

// File: rtl/fb_page_reader_pkg.sv
// Shared types and geometry for the framebuffer page reader.
// Address helper keeps the {p,k,g} offset layout in one place.
package fb_page_reader_pkg;

  localparam int FB_W     = 64;
  localparam int FB_H     = 32;
  localparam int FB_PAGES = 4;
  localparam int FB_BYTES = 256;

  localparam logic [11:0] FB_BASE_DEF = 12'hF00;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EMIT,
    DONE
  } state_t;

  // Row 8p+k, byte column g; the 12-bit sum wraps.
  function automatic logic [11:0] rd_addr(
    input logic [11:0] base,
    input logic [1:0]  p,
    input logic [2:0]  k,
    input logic [2:0]  g
  );
    return base + {4'd0, p, k, g};
  endfunction

endpackage

// File: rtl/fb_page_reader_if.sv
// Memory read port and page-byte stream of the reader.
// master = reader side, slave = memory/sink side.
interface fb_page_reader_if;

  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_data,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_data,
    input  out_data, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/fb_transpose8.sv
// 8x8-bit transpose buffer: rows written by k,
// column c read back as one byte (bit k = row k, pixel c).
module fb_transpose8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [2:0] wrow,
  input  logic [7:0] wdata,
  input  logic [2:0] col,
  output logic [7:0] cdata
);

  logic [7:0] rows [8];

  // Row storage, cleared so a fresh frame never sees stale bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rows[i] <= '0;
    end else if (we) begin
      rows[wrow] <= wdata;
    end
  end

  // Column select: MSB of a row is the leftmost pixel (c = 0).
  always_comb begin
    cdata = '0;
    for (int k = 0; k < 8; k++) begin
      cdata[k] = rows[k][3'd7 - col];
    end
  end

endmodule

// File: rtl/fb_page_reader.sv
// Streams the 64x32 framebuffer as 256 vertical page bytes,
// one 8x8 block at a time: 8 row reads, then 8 column bytes.
module fb_page_reader
  import fb_page_reader_pkg::*;
#(
  parameter logic [11:0] FB_BASE = FB_BASE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  fb_page_reader_if.master bus
);

  state_t     state;
  logic [1:0] p;
  logic [2:0] g;
  logic [2:0] k;
  logic [2:0] c;
  logic [4:0] pg_nxt;
  logic [7:0] col;
  logic       wr_en;
  logic       last_grp;

  assign pg_nxt   = {p, g} + 5'd1;
  assign last_grp = (p == 2'd3) && (g == 3'd7);
  assign wr_en    = (state == READ) && bus.mem_ack;

  fb_transpose8 u_tp (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .wrow  (k),
    .wdata (bus.mem_data),
    .col   (c),
    .cdata (col)
  );

  // Gated so the stream reads 0 whenever nothing is offered.
  assign bus.out_data = bus.out_valid ? col : 8'h00;

  // Frame sequencer; all handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      p             <= '0;
      g             <= '0;
      k             <= '0;
      c             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= READ;
            p            <= '0;
            g            <= '0;
            k            <= '0;
            c            <= '0;
            busy         <= 1'b1;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= rd_addr(FB_BASE, 2'd0, 3'd0, 3'd0);
          end
        end
        READ: begin
          if (bus.mem_ack) begin
            k <= k + 3'd1;
            if (k == 3'd7) begin
              state         <= EMIT;
              c             <= '0;
              bus.mem_req   <= 1'b0;
              bus.out_valid <= 1'b1;
            end else begin
              bus.mem_addr <=
                rd_addr(FB_BASE, p, k + 3'd1, g);
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            c            <= c + 3'd1;
            bus.out_last <= last_grp && (c == 3'd6);
            if (c == 3'd7) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              if (last_grp) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state        <= READ;
                p            <= pg_nxt[4:3];
                g            <= pg_nxt[2:0];
                k            <= '0;
                bus.mem_req  <= 1'b1;
                bus.mem_addr <= rd_addr(FB_BASE,
                  pg_nxt[4:3], 3'd0, pg_nxt[2:0]);
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_page_reader.sv
// Random-stimulus bench for fb_page_reader against a
// pixel-level model of the framebuffer and its read order.
module tb_fb_page_reader;
  import fb_page_reader_pkg::*;

  localparam logic [11:0] BASE = 12'hF00;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  fb_page_reader_if bus ();

  fb_page_reader #(.FB_BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [4096];
  int          ready_mode;
  int          ack_mode;
  int          cyc;
  int          cur_delay;
  int          wait_cnt;
  bit          tog;
  logic [7:0]  got_data [$];
  bit          got_last [$];
  logic [11:0] addr_log [$];
  int          done_cnt;
  int          hs_cnt;
  int          last_hs_cyc;
  int          done_cyc;
  int          first_req_cyc;
  bit          seen_req;
  logic        prev_req;
  logic [11:0] prev_addr;
  logic        prev_ack;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // Pixel (x,y) lives at bit 7-x%8 of BASE+8y+x/8.
  function automatic logic [7:0] exp_byte(input int i);
    int p;
    int x;
    logic [7:0] b;
    logic [7:0] r;
    p = i / 64;
    x = i % 64;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      b = mem[(int'(BASE) + 8 * (8 * p + k) + x / 8) % 4096];
      r[k] = b[7 - x % 8];
    end
    return r;
  endfunction

  // j-th read: group j/8 = (p,g), row k within the page.
  function automatic logic [11:0] exp_addr(input int j);
    int grp;
    int a;
    grp = j / 8;
    a = int'(BASE) + 8 * (8 * (grp / 8) + j % 8) + grp % 8;
    return 12'(a % 4096);
  endfunction

  function automatic int new_delay();
    if (ack_mode < 0) return int'($urandom_range(0, 3));
    return ack_mode;
  endfunction

  // Memory responder, sink and protocol monitor.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_data  = 8'h00;
    bus.out_ready = 1'b0;
    cyc = 0; wait_cnt = 0; cur_delay = 0; tog = 1'b0;
    done_cnt = 0; hs_cnt = 0; last_hs_cyc = -10;
    done_cyc = 0; first_req_cyc = 0; seen_req = 1'b0;
    prev_req = 1'b0; prev_addr = '0; prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_req && bus.mem_req && !prev_ack)
        chk("addr_stable", bus.mem_addr, prev_addr);
      if (bus.mem_req && !seen_req) begin
        seen_req = 1'b1;
        first_req_cyc = cyc;
      end
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: begin tog = ~tog; bus.out_ready = tog; end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (!bus.out_valid)
        chk("last_idle", {31'd0, bus.out_last}, 0);
      if (bus.mem_req && wait_cnt >= cur_delay) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = mem[bus.mem_addr];
        addr_log.push_back(bus.mem_addr);
        wait_cnt = 0;
        cur_delay = new_delay();
      end else begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
        wait_cnt = bus.mem_req ? wait_cnt + 1 : 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", {31'd0, busy}, 0);
        chk("done_lat", cyc, last_hs_cyc + 1);
      end
      prev_req  = bus.mem_req;
      prev_addr = bus.mem_addr;
      prev_ack  = bus.mem_ack;
    end
  end

  task automatic clear_mem();
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
  endtask

  task automatic rand_fb();
    for (int a = 0; a < 256; a++)
      mem[int'(BASE) + a] = 8'($urandom);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_req"}, {31'd0, bus.mem_req}, 0);
    chk({tag, "_addr"}, {20'd0, bus.mem_addr}, 0);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 0);
    chk({tag, "_last"}, {31'd0, bus.out_last}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_data"}, {24'd0, bus.out_data}, 0);
  endtask

  task automatic begin_frame();
    @(negedge clk);
    got_data.delete();
    got_last.delete();
    addr_log.delete();
    hs_cnt = 0;
    seen_req = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_req", {31'd0, bus.mem_req}, 1);
    chk("start_addr", {20'd0, bus.mem_addr}, {20'd0, BASE});
    chk("start_busy", {31'd0, busy}, 1);
  endtask

  task automatic run_frame(input bit spam, input bit min_t);
    int d0;
    int t;
    int n;
    d0 = done_cnt;
    begin_frame();
    t = 0;
    while (done_cnt == d0 && t < 40000) begin
      @(negedge clk);
      t++;
      start = spam && (t == 20 || hs_cnt == 200);
    end
    start = 1'b0;
    if (min_t) chk("frame_len", done_cyc - first_req_cyc, 512);
    repeat (20) @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_req", {31'd0, bus.mem_req}, 0);
    chk("hs_count", got_data.size(), 256);
    n = got_data.size() < 256 ? got_data.size() : 256;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("byte%0d", i), {24'd0, got_data[i]},
          {24'd0, exp_byte(i)});
      chk($sformatf("last%0d", i), {31'd0, got_last[i]},
          (i == 255) ? 1 : 0);
    end
    chk("rd_count", addr_log.size(), 256);
    n = addr_log.size() < 256 ? addr_log.size() : 256;
    for (int j = 0; j < n; j++)
      chk($sformatf("addr%0d", j), {20'd0, addr_log[j]},
          {20'd0, exp_addr(j)});
  endtask

  initial begin
    int d0;
    int t;
    reset = 1'b1;
    start = 1'b0;
    ready_mode = 0;
    ack_mode = 0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    reset = 1'b0;

    // All-zero frame, minimum timing.
    run_frame(1'b0, 1'b1);

    // Top-left pixel.
    mem[12'hF00] = 8'h80;
    run_frame(1'b0, 1'b1);

    // Bottom-right pixel.
    clear_mem();
    mem[12'hFFF] = 8'h01;
    run_frame(1'b0, 1'b1);

    // Checkerboard, toggling sink, slow memory.
    for (int a = 0; a < 256; a++)
      mem[int'(BASE) + a] = ((a / 8) % 2) ? 8'h55 : 8'hAA;
    ready_mode = 1;
    ack_mode = 3;
    run_frame(1'b0, 1'b0);

    // Random image, random stalls, extra starts while busy.
    rand_fb();
    ready_mode = 2;
    ack_mode = -1;
    run_frame(1'b1, 1'b0);

    // Reset mid-frame at byte 100.
    rand_fb();
    d0 = done_cnt;
    begin_frame();
    t = 0;
    while (hs_cnt < 100 && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk("hs_reach100", {31'd0, hs_cnt >= 100}, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_nodone", done_cnt - d0, 0);
    chk("midrst_idle", {31'd0, bus.mem_req}, 0);
    run_frame(1'b0, 1'b0);

    // start together with reset is dropped.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {31'd0, busy}, 0);
    chk("rst_start_req", {31'd0, bus.mem_req}, 0);

    // Further random frames.
    for (int f = 0; f < 3; f++) begin
      rand_fb();
      ready_mode = (f == 0) ? 0 : 2;
      ack_mode = (f == 1) ? 0 : -1;
      run_frame(1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
